decode_queue_stage: RTL and testbench

Parametrised replacement for the single-entry fetch/decode pipeline register. It holds a DEPTH-entry circular queue of fetch bundles (instruction, PC, PC+4, predicted target, prediction bit) with a valid/ready handshake toward fetch. The head entry is split into decode fields, and its immediate is extended through the existing imm_extend block. It decouples fetch from decode stalls, sitting between the fetch stage and the decode/hazard logic.

---
 rtl/decode_queue_stage.sv | 164 ++++++++++++++++
 tb/tb_decode_queue_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue_stage.sv
// DEPTH-entry circular queue of fetch bundles between fetch and decode, with head-field split and immediate extension.
// Optional `define DECODE_QUEUE_PERF_EN adds full_cycles_o / empty_cycles_o saturating occupancy counters.

module imm_extend (
  input  logic [31:7] instr_i,
  input  logic [2:0]  imm_src_i,
  output logic [31:0] imm_ext_o
);
  // 0:I 1:S 2:B 3:J 4:U; other codes give zero.
  always_comb begin
    imm_ext_o = '0;
    case (imm_src_i)
      3'd0: imm_ext_o = {{20{instr_i[31]}}, instr_i[31:20]};
      3'd1: imm_ext_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      3'd2: imm_ext_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      3'd3: imm_ext_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      3'd4: imm_ext_o = {instr_i[31:12], 12'b0};
      default: imm_ext_o = '0;
    endcase
  end
endmodule

module decode_queue_stage #(
  parameter int DEPTH   = 2,
  parameter int ENTRY_W = 129
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [31:0]                instr_f_i,
  input  logic [31:0]                pc_f_i,
  input  logic [31:0]                pc_plus4_f_i,
  input  logic [31:0]                pred_pc_target_f_i,
  input  logic                       pc_src_pred_f_i,
  input  logic                       valid_f_i,
  output logic                       ready_f_o,
  input  logic [2:0]                 imm_src_d_i,
  input  logic                       stall_d_i,
  input  logic                       flush_d_i,
  output logic                       valid_d_o,
  output logic [31:0]                imm_ext_d_o,
  output logic [31:0]                pc_d_o,
  output logic [31:0]                pc_plus4_d_o,
  output logic [31:0]                pred_pc_target_d_o,
  output logic [4:0]                 rd_d_o,
  output logic [4:0]                 rs1_d_o,
  output logic [4:0]                 rs2_d_o,
  output logic [6:0]                 op_d_o,
  output logic [2:0]                 funct3_d_o,
  output logic [6:0]                 funct7_d_o,
  output logic                       pc_src_pred_d_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef DECODE_QUEUE_PERF_EN
  ,
  output logic [31:0]                full_cycles_o,
  output logic [31:0]                empty_cycles_o
`endif
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;
  logic [ENTRY_W-1:0] head;
  logic [31:0]        head_instr;

  assign ready_f_o = (count_q < DEPTH_C);
  assign valid_d_o = (count_q != '0);
  assign count_o   = count_q;
  assign push      = valid_f_i & ready_f_o;
  assign pop       = valid_d_o & ~stall_d_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push)
      mem_d[wr_ptr_q] = {instr_f_i, pc_f_i, pc_plus4_f_i, pred_pc_target_f_i, pc_src_pred_f_i};
    if (flush_d_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage has no reset; contents are only observed while count is non-zero.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head       = valid_d_o ? mem_q[rd_ptr_q] : '0;
  assign head_instr = head[128:97];

  assign pc_d_o             = head[96:65];
  assign pc_plus4_d_o       = head[64:33];
  assign pred_pc_target_d_o = head[32:1];
  assign pc_src_pred_d_o    = head[0];
  assign op_d_o             = head_instr[6:0];
  assign rd_d_o             = head_instr[11:7];
  assign funct3_d_o         = head_instr[14:12];
  assign rs1_d_o            = head_instr[19:15];
  assign rs2_d_o            = head_instr[24:20];
  assign funct7_d_o         = head_instr[31:25];

  imm_extend u_imm_extend (
    .instr_i   (head_instr[31:7]),
    .imm_src_i (imm_src_d_i),
    .imm_ext_o (imm_ext_d_o)
  );

`ifdef DECODE_QUEUE_PERF_EN
  logic [31:0] full_cycles_q, full_cycles_d, empty_cycles_q, empty_cycles_d;

  always_comb begin
    full_cycles_d  = full_cycles_q;
    empty_cycles_d = empty_cycles_q;
    if (flush_d_i) begin
      full_cycles_d  = '0;
      empty_cycles_d = '0;
    end else begin
      if (count_q == DEPTH_C && full_cycles_q != '1)
        full_cycles_d = full_cycles_q + 32'd1;
      if (count_q == '0 && valid_f_i && empty_cycles_q != '1)
        empty_cycles_d = empty_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_cycles_q  <= '0;
      empty_cycles_q <= '0;
    end else begin
      full_cycles_q  <= full_cycles_d;
      empty_cycles_q <= empty_cycles_d;
    end
  end

  assign full_cycles_o  = full_cycles_q;
  assign empty_cycles_o = empty_cycles_q;
`endif

endmodule

// File: tb/tb_decode_queue_stage.sv
// Directed bench for decode_queue_stage (DEPTH=2): reset, single pass, fill/full, flush, push+pop, streamed wrap.

module tb_decode_queue_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_f, pc_f, pc_plus4_f, pred_f;
  logic        pred_bit_f, valid_f, ready_f;
  logic [2:0]  imm_src;
  logic        stall, flush, valid_d;
  logic [31:0] imm_ext, pc_d, pc_plus4_d, pred_d;
  logic [4:0]  rd_d, rs1_d, rs2_d;
  logic [6:0]  op_d, funct7_d;
  logic [2:0]  funct3_d;
  logic        pred_bit_d;
  logic [1:0]  count;
`ifdef DECODE_QUEUE_PERF_EN
  logic [31:0] full_cycles, empty_cycles;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  decode_queue_stage #(.DEPTH(DEPTH)) dut (
    .clk_i              (clk),
    .reset_i            (rst),
    .instr_f_i          (instr_f),
    .pc_f_i             (pc_f),
    .pc_plus4_f_i       (pc_plus4_f),
    .pred_pc_target_f_i (pred_f),
    .pc_src_pred_f_i    (pred_bit_f),
    .valid_f_i          (valid_f),
    .ready_f_o          (ready_f),
    .imm_src_d_i        (imm_src),
    .stall_d_i          (stall),
    .flush_d_i          (flush),
    .valid_d_o          (valid_d),
    .imm_ext_d_o        (imm_ext),
    .pc_d_o             (pc_d),
    .pc_plus4_d_o       (pc_plus4_d),
    .pred_pc_target_d_o (pred_d),
    .rd_d_o             (rd_d),
    .rs1_d_o            (rs1_d),
    .rs2_d_o            (rs2_d),
    .op_d_o             (op_d),
    .funct3_d_o         (funct3_d),
    .funct7_d_o         (funct7_d),
    .pc_src_pred_d_o    (pred_bit_d),
    .count_o            (count)
`ifdef DECODE_QUEUE_PERF_EN
    ,
    .full_cycles_o      (full_cycles),
    .empty_cycles_o     (empty_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    valid_f    = v;
    instr_f    = instr;
    pc_f       = pc;
    pc_plus4_f = pc + 32'd4;
    pred_f     = pc + 32'h40;
    pred_bit_f = pc[2];
  endtask

  initial begin
    int pushed, popped, cycles;
    logic [31:0] exp_pc;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; imm_src = 3'd0;
    drive(1'b0, 32'h0, 32'h0);
    #2;
    check("reset_count", 32'(count), 32'd0);
    check("reset_valid", 32'(valid_d), 32'd0);
    check("reset_ready", 32'(ready_f), 32'd1);
    step();
    rst = 1'b0;
    step();

    // Single pass: addi x1,x0,10 held by stall for inspection.
    stall = 1'b1;
    drive(1'b1, 32'h00A00093, 32'h100);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("single_valid", 32'(valid_d), 32'd1);
    check("single_rd", 32'(rd_d), 32'd1);
    check("single_rs1", 32'(rs1_d), 32'd0);
    check("single_imm", imm_ext, 32'd10);
    check("single_pc", pc_d, 32'h100);
    check("single_pc4", pc_plus4_d, 32'h104);
    check("single_pred", pred_d, 32'h140);
    check("single_op", 32'(op_d), 32'h13);
    check("single_count", 32'(count), 32'd1);
    stall = 1'b0;
    step();
    check("empty_valid", 32'(valid_d), 32'd0);
    check("empty_op", 32'(op_d), 32'd0);
    check("empty_pc", pc_d, 32'd0);
    check("empty_imm", imm_ext, 32'd0);

    // Fill to full under stall, third bundle waits.
    stall = 1'b1;
    drive(1'b1, 32'h00000013, 32'h200);
    step();
    drive(1'b1, 32'hFFF00113, 32'h204);
    step();
    check("full_count", 32'(count), 32'd2);
    check("full_ready", 32'(ready_f), 32'd0);
    check("full_head", pc_d, 32'h200);
    drive(1'b1, 32'h00000193, 32'h208);
    step();
    check("full_hold_count", 32'(count), 32'd2);
    check("full_hold_head", pc_d, 32'h200);
    stall = 1'b0;
    step();
    check("drain1_count", 32'(count), 32'd1);
    check("drain1_head", pc_d, 32'h204);
    check("drain1_imm", imm_ext, 32'hFFFF_FFFF);
    check("drain1_rd", 32'(rd_d), 32'd2);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("drain2_count", 32'(count), 32'd1);
    check("drain2_head", pc_d, 32'h208);
    step();
    check("drain3_count", 32'(count), 32'd0);

    // Asynchronous reset with the queue full.
    stall = 1'b1;
    drive(1'b1, 32'h00A00093, 32'h500);
    step();
    drive(1'b1, 32'h00A00093, 32'h504);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("prereset_count", 32'(count), 32'd2);
    rst = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_valid", 32'(valid_d), 32'd0);
    check("async_rst_ready", 32'(ready_f), 32'd1);
    check("async_rst_op", 32'(op_d), 32'd0);
    #2;
    rst = 1'b0;
    step();

    // Flush beats push and pop; a bundle pushed in the flush cycle is lost.
    drive(1'b1, 32'h00000013, 32'h300);
    step();
    stall = 1'b0; flush = 1'b1;
    drive(1'b1, 32'h00000013, 32'h304);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush1_count", 32'(count), 32'd0);
    check("flush1_valid", 32'(valid_d), 32'd0);
    step();
    check("flush1_after", 32'(count), 32'd0);
    stall = 1'b1;
    drive(1'b1, 32'h00000013, 32'h310);
    step();
    drive(1'b1, 32'h00000013, 32'h314);
    step();
    stall = 1'b0; flush = 1'b1;
    drive(1'b1, 32'h00000013, 32'h318);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush2_count", 32'(count), 32'd0);
    check("flush2_valid", 32'(valid_d), 32'd0);
    step();
    check("flush2_after", 32'(valid_d), 32'd0);

    // Simultaneous push and pop at count 1.
    stall = 1'b1;
    drive(1'b1, 32'h00000013, 32'h400);
    step();
    stall = 1'b0;
    drive(1'b1, 32'h00000013, 32'h404);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("pushpop_count", 32'(count), 32'd1);
    check("pushpop_head", pc_d, 32'h404);
    check("pushpop_pred_bit", 32'(pred_bit_d), 32'd1);
    step();
    check("pushpop_drain", 32'(count), 32'd0);

`ifdef DECODE_QUEUE_PERF_EN
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("perf_clr_full", full_cycles, 32'd0);
    check("perf_clr_empty", empty_cycles, 32'd0);
    step();
    check("perf_idle_empty", empty_cycles, 32'd0);
    stall = 1'b1;
    drive(1'b1, 32'h00000013, 32'h600);
    step();
    check("perf_empty_one", empty_cycles, 32'd1);
    step();
    check("perf_not_full", full_cycles, 32'd0);
    step();
    check("perf_full_one", full_cycles, 32'd1);
    check("perf_empty_hold", empty_cycles, 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    stall = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("perf_flush_full", full_cycles, 32'd0);
`endif

    // Stream 10 bundles with random stalls; the pointers wrap several times.
    pushed = 0; popped = 0; cycles = 0;
    exp_q.delete();
    while (popped < 10 && cycles < 300) begin
      stall = 1'($urandom_range(0, 1));
      if (pushed < 10) drive(1'b1, 32'h00000013, 32'(pushed * 4));
      else drive(1'b0, 32'h0, 32'h0);
      #1;
      check("stream_count", 32'(count), 32'(exp_q.size()));
      check("stream_ready", 32'(ready_f), 32'(exp_q.size() < DEPTH));
      if (valid_d && !stall) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected_pop", pc_d, 32'hDEAD_BEEF);
        end else begin
          exp_pc = exp_q.pop_front();
          check("stream_pc", pc_d, exp_pc);
        end
        popped++;
      end
      if (valid_f && ready_f) begin
        exp_q.push_back(pc_f);
        pushed++;
      end
      step();
      cycles++;
    end
    check("stream_popped", 32'(popped), 32'd10);
    drive(1'b0, 32'h0, 32'h0);
    stall = 1'b0;
    step();
    check("stream_final_count", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
